ransac_inlier_scorer: RTL and testbench
=======================================

// Module: ransac_inlier_scorer
// PURPOSE
//  Sequencer for the fast point-to-plane distance datapath in the RANSAC scoring stage.
//  - Accepts one candidate plane, an inlier threshold and a point count.
//  - Streams that many points through the distance unit at up to 1 point/cycle.
//  - Counts the points whose distance is <= threshold and returns the inlier count
//    over a valid/ready handshake.
//  - Sits between the hypothesis generator (upstream) and the best-model selector (downstream).
// PARAMETERS
//  COUNT_BITS        32                              width of point_count / inlier_count
//  MULTIPLY_LATENCY  ransac_fixed::value_bits()/8    forwarded to the distance unit
//  FLUSH_CYCLES      4*MULTIPLY_LATENCY+8            cycles held in FLUSH after reset; >= datapath depth
// PORTS
//  clock         in   1           rising-edge clock
//  reset_n       in   1           asynchronous, active-low reset
//  start_valid   in   1           job request
//  start_ready   out  1           job accepted when start_valid & start_ready
//  plane         in   plane_t     candidate plane; latched on job accept
//  threshold     in   fixed_t     inlier threshold; latched on job accept
//  point_count   in   COUNT_BITS  points in the job; latched on job accept
//  point_valid   in   1           point stream valid
//  point_ready   out  1           point stream ready
//  point         in   point_t     point; consumed when point_valid & point_ready
//  done_valid    out  1           result available
//  done_ready    in   1           result consumed when done_valid & done_ready
//  inlier_count  out  COUNT_BITS  result; stable while done_valid is high
//  busy          out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset values (reset_n low): state=FLUSH, start_ready=0, point_ready=0, done_valid=0,
//    busy=1, inlier_count=0; all internal counters = 0.
//  States:
//  - FLUSH: count FLUSH_CYCLES, then go to IDLE.
//    Tags returned in FLUSH are discarded; the datapath pipeline has no reset.
//  - IDLE: start_ready=1. On accept, latch plane/threshold/count, clear issued/received/inliers.
//    -> STREAM if count!=0; -> DONE if count==0 (result 0).
//  - STREAM: point_ready = (issued != count).
//    Each accepted point is issued to the datapath with tag.valid=1; issued++.
//    Cycles without an accept issue tag.valid=0.
//    When the final point is accepted -> DRAIN (same edge).
//  - DRAIN: point_ready=0. -> DONE when received == issued.
//  - DONE: done_valid=1, inlier_count held. On done_ready -> IDLE (start_ready rises next cycle).
//  Result collection (STREAM/DRAIN only): on returning tag.valid, received++.
//    If distance <= threshold (signed fixed compare; equality counts), inliers++.
//  start_valid outside IDLE: ignored, not queued.
//  point_valid outside STREAM: ignored; the point is not consumed.
//  inlier_count cannot exceed point_count; no saturation logic is required.
//  A result may return on the same edge as the last issue; counters use registered values,
//    and DRAIN exit is evaluated on the updated counts.
//  reset_n asserted mid-job: the job is abandoned silently; state restarts in FLUSH.
//  Throughput: 1 point/cycle while point_valid is held.
//  Job latency: count + datapath latency + 2 cycles from accept to done_valid.
// STRUCTURE
//  - ransac_fixed package gains:
//    - typedef struct packed {logic valid;} scorer_tag_t, the datapath external_pipeline type;
//    - function fixed_le(a,b).
//  - Sub-module: exactly one fast_point_distance_to_plane instance, with
//    external_pipeline=scorer_tag_t and multiply_latency=MULTIPLY_LATENCY.
//  - State enum local to this module: FLUSH, IDLE, STREAM, DRAIN, DONE.
//  - Counters issued/received/inliers are COUNT_BITS wide.
// TESTING
//  1) Reset, wait FLUSH_CYCLES -> start_ready=1, busy=0, done_valid=0; no spurious done.
//  2) Plane z=0 (normal 0,0,1; d=0), thr=1.0, 4 points with z=0.5,-0.5,2.0,1.0 streamed back-to-back
//     -> point_ready high 4 consecutive cycles; done_valid with inlier_count=3 (1.0 counts).
//  3) point_count=0 -> done_valid 1 cycle after accept, inlier_count=0, point_ready never high.
//  4) 100 points, point_valid randomly gapped, done_ready held low 10 cycles
//     -> count matches model; inlier_count stable until done_ready; then IDLE.
//  5) start_valid pulsed during STREAM and DONE -> ignored; only one done per accepted job.
//  6) reset_n low mid-STREAM (after 5 of 10 points), new 3-point job after FLUSH
//     -> result reflects only the 3 new points.

Source files
------------

// File: rtl/ransac_fixed.sv
// Fixed-point (Q16.16) types and helpers shared by the RANSAC scoring datapath,
// plus the tag carried alongside each point through the distance pipeline.
package ransac_fixed;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } point_t;

    // Plane a*x + b*y + c*z + d = 0 with (a, b, c) a unit normal.
    typedef struct packed {
        fixed_t a;
        fixed_t b;
        fixed_t c;
        fixed_t d;
    } plane_t;

    typedef struct packed {
        logic valid;
    } scorer_tag_t;

    function automatic int value_bits();
        return $bits(fixed_t);
    endfunction

    function automatic fixed_t fixed_mul(input fixed_t a, input fixed_t b);
        logic signed [63:0] wide_a;
        logic signed [63:0] wide_b;
        logic signed [63:0] product;
        wide_a  = a;
        wide_b  = b;
        product = wide_a * wide_b;
        return fixed_t'(product >>> FRAC_BITS);
    endfunction

    function automatic fixed_t fixed_abs(input fixed_t a);
        return (a < 32'sd0) ? -a : a;
    endfunction

    function automatic logic fixed_le(input fixed_t a, input fixed_t b);
        return (a <= b);
    endfunction

endpackage

// File: rtl/fast_point_distance_to_plane.sv
// Pipelined |a*x + b*y + c*z + d| unit; a caller-defined tag travels alongside each
// point. The pipeline carries no reset, so early outputs are meaningless until flushed.
module fast_point_distance_to_plane
    import ransac_fixed::*;
#(
    parameter type external_pipeline = scorer_tag_t,
    parameter int  multiply_latency   = 4
) (
    input  logic             clock,
    input  plane_t           plane,
    input  point_t           point,
    input  external_pipeline in_pipeline,
    output fixed_t           distance,
    output external_pipeline out_pipeline
);

    typedef struct packed {
        fixed_t           px;
        fixed_t           py;
        fixed_t           pz;
        fixed_t           d;
        external_pipeline tag;
    } mul_stage_t;

    mul_stage_t       mul_r [multiply_latency];
    fixed_t           sum_r;
    external_pipeline sum_tag_r;
    fixed_t           dist_r;
    external_pipeline dist_tag_r;

    // Multiply stages, then the signed sum, then the absolute value.
    always_ff @(posedge clock) begin
        mul_r[0].px  <= fixed_mul(plane.a, point.x);
        mul_r[0].py  <= fixed_mul(plane.b, point.y);
        mul_r[0].pz  <= fixed_mul(plane.c, point.z);
        mul_r[0].d   <= plane.d;
        mul_r[0].tag <= in_pipeline;
        for (int i = 1; i < multiply_latency; i++) begin
            mul_r[i] <= mul_r[i-1];
        end
        sum_r      <= mul_r[multiply_latency-1].px + mul_r[multiply_latency-1].py
                    + mul_r[multiply_latency-1].pz + mul_r[multiply_latency-1].d;
        sum_tag_r  <= mul_r[multiply_latency-1].tag;
        dist_r     <= fixed_abs(sum_r);
        dist_tag_r <= sum_tag_r;
    end

    assign distance     = dist_r;
    assign out_pipeline = dist_tag_r;

endmodule

// File: rtl/ransac_inlier_scorer.sv
// Job sequencer for the RANSAC scoring stage: streams one job's points through the
// distance unit and counts those within the threshold of the candidate plane.
module ransac_inlier_scorer
    import ransac_fixed::*;
#(
    parameter int COUNT_BITS       = 32,
    parameter int MULTIPLY_LATENCY = value_bits() / 8,
    parameter int FLUSH_CYCLES     = 4 * MULTIPLY_LATENCY + 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  plane_t                plane,
    input  fixed_t                threshold,
    input  logic [COUNT_BITS-1:0] point_count,
    input  logic                  point_valid,
    output logic                  point_ready,
    input  point_t                point,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [COUNT_BITS-1:0] inlier_count,
    output logic                  busy
);

    typedef enum logic [2:0] {
        FLUSH  = 3'd0,
        IDLE   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [31:0]           FLUSH_LAST = 32'(FLUSH_CYCLES - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_ONE  = COUNT_BITS'(1);

    state_t                state_r;
    logic [31:0]           flush_count_r;
    plane_t                plane_r;
    fixed_t                threshold_r;
    logic [COUNT_BITS-1:0] count_r;
    logic [COUNT_BITS-1:0] issued_r;
    logic [COUNT_BITS-1:0] received_r;
    logic [COUNT_BITS-1:0] inliers_r;
    logic [COUNT_BITS-1:0] inlier_count_r;
    logic                  start_ready_r;
    logic                  point_ready_r;
    logic                  done_valid_r;
    logic                  busy_r;

    scorer_tag_t           issue_tag_s;
    scorer_tag_t           return_tag_s;
    fixed_t                distance_s;
    logic                  point_fire_s;
    logic                  collect_s;
    logic                  hit_s;
    logic [COUNT_BITS-1:0] issued_next_s;
    logic [COUNT_BITS-1:0] received_next_s;
    logic [COUNT_BITS-1:0] inliers_next_s;

    fast_point_distance_to_plane #(
        .external_pipeline (scorer_tag_t),
        .multiply_latency  (MULTIPLY_LATENCY)
    ) u_distance (
        .clock        (clock),
        .plane        (plane_r),
        .point        (point),
        .in_pipeline  (issue_tag_s),
        .distance     (distance_s),
        .out_pipeline (return_tag_s)
    );

    // Issue/collect decisions; tags returning outside STREAM/DRAIN are stale and dropped.
    always_comb begin
        point_fire_s      = (state_r == STREAM) && point_valid && point_ready_r;
        issue_tag_s.valid = point_fire_s;
        collect_s         = ((state_r == STREAM) || (state_r == DRAIN)) && return_tag_s.valid;
        hit_s             = collect_s && fixed_le(distance_s, threshold_r);
        issued_next_s     = point_fire_s ? (issued_r + COUNT_ONE) : issued_r;
        received_next_s   = collect_s ? (received_r + COUNT_ONE) : received_r;
        inliers_next_s    = hit_s ? (inliers_r + COUNT_ONE) : inliers_r;
    end

    // Job sequencer with registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= FLUSH;
            flush_count_r  <= '0;
            plane_r        <= '0;
            threshold_r    <= '0;
            count_r        <= '0;
            issued_r       <= '0;
            received_r     <= '0;
            inliers_r      <= '0;
            inlier_count_r <= '0;
            start_ready_r  <= 1'b0;
            point_ready_r  <= 1'b0;
            done_valid_r   <= 1'b0;
            busy_r         <= 1'b1;
        end else begin
            case (state_r)
                FLUSH: begin
                    if (flush_count_r == FLUSH_LAST) begin
                        state_r       <= IDLE;
                        flush_count_r <= '0;
                        start_ready_r <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        flush_count_r <= flush_count_r + 32'd1;
                    end
                end
                IDLE: begin
                    if (start_valid && start_ready_r) begin
                        plane_r       <= plane;
                        threshold_r   <= threshold;
                        count_r       <= point_count;
                        issued_r      <= '0;
                        received_r    <= '0;
                        inliers_r     <= '0;
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        if (point_count == '0) begin
                            state_r        <= DONE;
                            done_valid_r   <= 1'b1;
                            inlier_count_r <= '0;
                        end else begin
                            state_r       <= STREAM;
                            point_ready_r <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    issued_r      <= issued_next_s;
                    received_r    <= received_next_s;
                    inliers_r     <= inliers_next_s;
                    point_ready_r <= (issued_next_s != count_r);
                    if (issued_next_s == count_r) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    received_r <= received_next_s;
                    inliers_r  <= inliers_next_s;
                    if (received_next_s == issued_r) begin
                        state_r        <= DONE;
                        done_valid_r   <= 1'b1;
                        inlier_count_r <= inliers_next_s;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state_r       <= IDLE;
                        done_valid_r  <= 1'b0;
                        start_ready_r <= 1'b1;
                        busy_r        <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= FLUSH;
                    flush_count_r <= '0;
                    start_ready_r <= 1'b0;
                    point_ready_r <= 1'b0;
                    done_valid_r  <= 1'b0;
                    busy_r        <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready  = start_ready_r;
    assign point_ready  = point_ready_r;
    assign done_valid   = done_valid_r;
    assign inlier_count = inlier_count_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_ransac_inlier_scorer.sv
// Randomized self-checking bench for ransac_inlier_scorer; expected inlier counts come
// from exact integer plane arithmetic over the generated points.
module tb_ransac_inlier_scorer;
    import ransac_fixed::*;

    localparam int CB    = 32;
    localparam int FLUSH = 4 * (value_bits() / 8) + 8;
    localparam int MAXP  = 128;
    localparam int ONE   = 65536;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    plane_t        plane = '0;
    fixed_t        threshold = '0;
    logic [CB-1:0] point_count = '0;
    logic          point_valid = 1'b0;
    logic          point_ready;
    point_t        point = '0;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [CB-1:0] inlier_count;
    logic          busy;

    int     checks = 0;
    int     passes = 0;
    plane_t job_plane;
    fixed_t job_thr;
    int     job_axis;
    fixed_t px [MAXP];
    fixed_t py [MAXP];
    fixed_t pz [MAXP];

    ransac_inlier_scorer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .plane        (plane),
        .threshold    (threshold),
        .point_count  (point_count),
        .point_valid  (point_valid),
        .point_ready  (point_ready),
        .point        (point),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .inlier_count (inlier_count),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Exact distance in Q32.32: coefficients are whole multiples of 1.0, so no rounding.
    function automatic int model_count(input int n);
        int     hits;
        longint s;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            s = longint'(job_plane.a) * longint'(px[i]) + longint'(job_plane.b) * longint'(py[i])
              + longint'(job_plane.c) * longint'(pz[i]) + (longint'(job_plane.d) * 65536);
            if (s < 0) s = -s;
            if (s <= longint'(job_thr) * 65536) hits++;
        end
        return hits;
    endfunction

    function automatic fixed_t rand_signed(input int range);
        return fixed_t'(int'($urandom_range(0, 2 * range)) - range);
    endfunction

    task automatic make_random_job(input int n);
        int coeffs [4];
        int k;
        coeffs[0] = -2 * ONE; coeffs[1] = -ONE; coeffs[2] = ONE; coeffs[3] = 2 * ONE;
        k         = coeffs[$urandom_range(0, 3)];
        job_axis  = int'($urandom_range(0, 2));
        job_plane = '0;
        if (job_axis == 0) job_plane.a = k;
        else if (job_axis == 1) job_plane.b = k;
        else job_plane.c = k;
        job_plane.d = rand_signed(ONE);
        job_thr     = fixed_t'($urandom_range(ONE, 8 * ONE));
        for (int i = 0; i < n; i++) begin
            px[i] = rand_signed(16 * ONE);
            py[i] = rand_signed(16 * ONE);
            pz[i] = rand_signed(16 * ONE);
            if (job_axis == 0) px[i] = rand_signed(6 * ONE);
            else if (job_axis == 1) py[i] = rand_signed(6 * ONE);
            else pz[i] = rand_signed(6 * ONE);
        end
    endtask

    task automatic start_job(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            start_valid = 1'b1;
            plane       = job_plane;
            threshold   = job_thr;
            point_count = CB'(n);
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1 start_valid = 1'b0;
    endtask

    task automatic stream(input int n, input int gap_pct, input bit pulse_start,
                          output int iters, output bit start_ready_seen);
        int idx;
        bit rdy;
        idx              = 0;
        iters            = 0;
        start_ready_seen = 1'b0;
        while (idx < n && iters < 2000) begin
            @(negedge clock);
            point       = '{x: px[idx], y: py[idx], z: pz[idx]};
            point_valid = ($urandom_range(0, 99) >= gap_pct);
            rdy         = point_ready;
            if (start_ready) start_ready_seen = 1'b1;
            if (pulse_start) begin
                start_valid = $urandom_range(0, 1);
                point_count = CB'(7);
            end
            @(posedge clock);
            if (point_valid && rdy) idx++;
            iters++;
        end
        #1;
        point_valid = 1'b0;
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        @(posedge clock);
        #1 done_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        int spurious;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (start_ready !== 1'b0) $display("FAIL reset_start_ready: got %b expected 0", start_ready); else passes++;
        checks++; if (point_ready !== 1'b0) $display("FAIL reset_point_ready: got %b expected 0", point_ready); else passes++;
        checks++; if (done_valid !== 1'b0) $display("FAIL reset_done_valid: got %b expected 0", done_valid); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else passes++;
        checks++; if (inlier_count !== '0) $display("FAIL reset_inlier_count: got %0d expected 0", inlier_count); else passes++;
        reset_n  = 1'b1;
        spurious = 0;
        for (int i = 0; i < FLUSH - 1; i++) begin
            @(negedge clock);
            if (done_valid || start_ready) spurious++;
        end
        checks++; if (spurious !== 0 || busy !== 1'b1)
            $display("FAIL flush_length: early ready/done %0d busy %b, expected 0 and busy 1", spurious, busy);
        else passes++;
        @(negedge clock);
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0)
            $display("FAIL flush_exit: start_ready %b busy %b done_valid %b, expected 1 0 0", start_ready, busy, done_valid);
        else passes++;
    endtask

    task automatic test_basic();
        bit ok;
        bit sr;
        int iters;
        job_plane   = '0;
        job_plane.c = ONE;
        job_thr     = ONE;
        pz[0] = ONE / 2; pz[1] = -ONE / 2; pz[2] = 2 * ONE; pz[3] = ONE;
        for (int i = 0; i < 4; i++) begin
            px[i] = rand_signed(16 * ONE);
            py[i] = rand_signed(16 * ONE);
        end
        start_job(4, ok);
        stream(4, 0, 1'b0, iters, sr);
        checks++; if (iters !== 4) $display("FAIL basic_back_to_back: took %0d cycles expected 4", iters); else passes++;
        wait_done(200, ok);
        checks++; if (!ok) $display("FAIL basic_done_timeout: done_valid %b expected 1", done_valid); else passes++;
        checks++; if (inlier_count !== CB'(3)) $display("FAIL basic_count: got %0d expected 3", inlier_count); else passes++;
        release_done();
        checks++; if (done_valid !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL basic_release: done_valid %b start_ready %b expected 0 1", done_valid, start_ready);
        else passes++;
    endtask

    task automatic test_zero_count();
        bit ok;
        int pr_high;
        make_random_job(1);
        start_job(0, ok);
        @(negedge clock);
        pr_high = point_ready;
        checks++; if (done_valid !== 1'b1) $display("FAIL zero_done_latency: done_valid %b expected 1", done_valid); else passes++;
        checks++; if (inlier_count !== '0) $display("FAIL zero_count: got %0d expected 0", inlier_count); else passes++;
        release_done();
        pr_high += point_ready;
        checks++; if (pr_high !== 0) $display("FAIL zero_point_ready: seen high %0d times expected 0", pr_high); else passes++;
    endtask

    task automatic test_random_gapped();
        bit ok;
        bit sr;
        int iters;
        int expected;
        int unstable;
        logic [CB-1:0] held;
        for (int job = 0; job < 3; job++) begin
            make_random_job(100);
            expected = model_count(100);
            start_job(100, ok);
            stream(100, 30, 1'b0, iters, sr);
            wait_done(500, ok);
            checks++; if (!ok) $display("FAIL random_done_timeout: job %0d done_valid %b expected 1", job, done_valid); else passes++;
            checks++; if (inlier_count !== CB'(expected))
                $display("FAIL random_count: job %0d got %0d expected %0d", job, inlier_count, expected);
            else passes++;
            held     = inlier_count;
            unstable = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                if (inlier_count !== held || done_valid !== 1'b1) unstable++;
            end
            checks++; if (unstable !== 0) $display("FAIL random_hold: %0d unstable cycles expected 0", unstable); else passes++;
            release_done();
            checks++; if (busy !== 1'b0 || start_ready !== 1'b1)
                $display("FAIL random_idle: busy %b start_ready %b expected 0 1", busy, start_ready);
            else passes++;
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        bit sr;
        int iters;
        int expected;
        int sr_done;
        int extra_done;
        make_random_job(20);
        expected = model_count(20);
        start_job(20, ok);
        stream(20, 20, 1'b1, iters, sr);
        checks++; if (sr !== 1'b0) $display("FAIL ignore_stream_ready: start_ready seen %b expected 0", sr); else passes++;
        wait_done(300, ok);
        sr_done = 0;
        for (int i = 0; i < 3; i++) begin
            start_valid = 1'b1;
            point_count = CB'(5);
            @(negedge clock);
            sr_done += start_ready;
        end
        start_valid = 1'b0;
        checks++; if (sr_done !== 0) $display("FAIL ignore_done_ready: start_ready seen %0d expected 0", sr_done); else passes++;
        checks++; if (inlier_count !== CB'(expected))
            $display("FAIL ignore_count: got %0d expected %0d", inlier_count, expected);
        else passes++;
        release_done();
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done_valid || busy) extra_done++;
        end
        checks++; if (extra_done !== 0) $display("FAIL ignore_queued: %0d busy/done cycles expected 0", extra_done); else passes++;
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        bit sr;
        int iters;
        int expected;
        make_random_job(10);
        start_job(10, ok);
        stream(5, 0, 1'b0, iters, sr);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b1 || point_ready !== 1'b0 || start_ready !== 1'b0 || done_valid !== 1'b0)
            $display("FAIL midreset_outputs: busy %b point_ready %b start_ready %b done_valid %b expected 1 0 0 0",
                     busy, point_ready, start_ready, done_valid);
        else passes++;
        reset_n = 1'b1;
        repeat (FLUSH + 2) @(negedge clock);
        job_plane   = '0;
        job_plane.c = ONE;
        job_thr     = ONE;
        pz[0] = ONE / 4; pz[1] = 3 * ONE; pz[2] = -ONE;
        for (int i = 0; i < 3; i++) begin
            px[i] = rand_signed(16 * ONE);
            py[i] = rand_signed(16 * ONE);
        end
        expected = model_count(3);
        start_job(3, ok);
        checks++; if (!ok) $display("FAIL midreset_accept: start_ready %b expected 1", start_ready); else passes++;
        stream(3, 0, 1'b0, iters, sr);
        wait_done(200, ok);
        checks++; if (inlier_count !== CB'(2) || inlier_count !== CB'(expected))
            $display("FAIL midreset_count: got %0d expected 2 (model %0d)", inlier_count, expected);
        else passes++;
        release_done();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_random_gapped();
        test_start_ignored();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
